// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit, one radix-2 step per cycle (32 steps).
// Optional macro MULDIV_FAST_MUL_EN makes MUL* ops single-cycle; divides stay iterative.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  // Handshake: start is sampled only while busy=0 and flush=0; operands are
  // captured on that edge. valid is a one-cycle strobe with result/rd_out
  // registered and held until the next strobe. There is no back-pressure.

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t            state, state_d;
  logic [4:0]        cnt, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   hi, hi_d;
  logic [XLEN-1:0]   lo, lo_d;
  logic [XLEN-1:0]   mcand, mcand_d;
  logic [4:0]        rd_q, rd_q_d;
  logic [XLEN-1:0]   result_d;
  logic [4:0]        rd_out_d;

  // Operand decode on the incoming request
  logic              a_signed, b_signed;
  logic              neg_a, neg_b, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   bypass_res;

  // One iteration of the shared shift datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   step_hi, step_lo;

  // Sign fix-up of the final step
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b001:         begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:         begin a_signed = 1'b1; end
      3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        ;
    endcase
  end

  assign neg_a      = a_signed & op_a[XLEN-1];
  assign neg_b      = b_signed & op_b[XLEN-1];
  assign mag_a      = neg_a ? -op_a : op_a;
  assign mag_b      = neg_b ? -op_b : op_b;
  // Remainders follow the dividend; products and quotients follow both signs
  assign neg_in     = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
  assign is_div     = funct3[2];
  assign div_zero   = is_div & (op_b == '0);
  assign div_ovf    = is_div & ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONE);
  assign bypass_res = div_zero ? (funct3[1] ? op_a : ALL_ONE)
                               : (funct3[1] ? '0   : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_a    = {{XLEN{neg_a}}, op_a};
  assign fast_b    = {{XLEN{neg_b}}, op_b};
  assign fast_prod = fast_a * fast_b;
`endif

  // Multiply: shift-add into {hi,lo}. Divide: restoring, remainder in hi, quotient into lo.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_trial = {hi, lo[XLEN-1]};
    div_diff  = div_trial - {1'b0, mcand};
    div_ge    = ~div_diff[XLEN];
    if (op_q[2]) begin
      step_hi = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
      step_lo = {lo[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -step_lo : step_lo;
    rem_fix  = neg_q ? -step_hi : step_hi;
    if (!op_q[2])
      calc_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      calc_res = op_q[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi;
    lo_d     = lo;
    mcand_d  = mcand;
    rd_q_d   = rd_q;
    result_d = result;
    rd_out_d = rd_out;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          op_d   = funct3;
          neg_d  = neg_in;
          rd_q_d = rd_in;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            result_d = bypass_res;
            rd_out_d = rd_in;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            result_d = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                               : fast_prod[2*XLEN-1:XLEN];
            rd_out_d = rd_in;
            state_d  = DONE;
          end
`endif
          else begin
            hi_d    = '0;
            lo_d    = is_div ? mag_a : mag_b;
            mcand_d = is_div ? mag_b : mag_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt + 5'd1;
        if (cnt == 5'd31) begin
          result_d = calc_res;
          rd_out_d = rd_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An aborted op must leave the previous result visible
    if (flush) begin
      state_d  = IDLE;
      result_d = result;
      rd_out_d = rd_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      rd_q   <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      hi     <= hi_d;
      lo     <= lo_d;
      mcand  <= mcand_d;
      rd_q   <= rd_q_d;
      result <= result_d;
      rd_out <= rd_out_d;
    end
  end

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit (latency, results, flush, reset).
// Build with MULDIV_FAST_MUL_EN defined to check the single-cycle multiply path.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .valid  (valid),
    .result (result),
    .rd_out (rd_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: issue one op, scramble inputs after the accepting edge, then
  // measure latency and compare against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input bit poke);
    int lat;
    bit seen;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start  = poke;
    funct3 = 3'($urandom_range(0, 7));
    op_a   = $urandom;
    op_b   = $urandom_range(0, 3);
    rd_in  = 5'($urandom_range(0, 31));
    exp_q.push_back(exp_res);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (valid) seen = 1'b1;
      else begin
        if (lat == 4) start = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp_q.pop_front());
    check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    @(posedge clk); #1;
    check({tag, " valid one-shot"}, {31'd0, valid}, 32'd0);
    check({tag, " result held"}, result, exp_res);
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Multiplies (first one accepted on the first edge after reset release)
    run_op("mul 7*-3",     3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, MUL_LAT, 1'b0);
    run_op("mulhu -1*-1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, MUL_LAT, 1'b0);
    run_op("mulh -1*-1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, MUL_LAT, 1'b0);
    run_op("mulhsu -1*u",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, MUL_LAT, 1'b0);
    run_op("mulh min*min", 3'b001, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, MUL_LAT, 1'b0);
    run_op("mul poke",     3'b000, 32'h12345678, 32'h00000010, 5'd8,  32'h23456780, MUL_LAT, MUL_LAT > 4);

    // Divides
    run_op("div -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, DIV_LAT, 1'b1);
    run_op("rem -7/2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, DIV_LAT, 1'b0);
    run_op("div 7/-2",     3'b100, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, DIV_LAT, 1'b0);
    run_op("rem 7/-2",     3'b110, 32'd7,        32'hFFFFFFFE, 5'd12, 32'h00000001, DIV_LAT, 1'b0);
    run_op("divu 100/7",   3'b101, 32'd100,      32'd7,        5'd13, 32'd14,       DIV_LAT, 1'b0);
    run_op("remu 100/7",   3'b111, 32'd100,      32'd7,        5'd14, 32'd2,        DIV_LAT, 1'b0);
    run_op("divu max/1",   3'b101, 32'hFFFFFFFF, 32'd1,        5'd15, 32'hFFFFFFFF, DIV_LAT, 1'b0);
    run_op("divu min/-1",  3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        DIV_LAT, 1'b0);

    // Bypassed corner cases
    run_op("divu 5/0",     3'b101, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1, 1'b0);
    run_op("remu 5/0",     3'b111, 32'd5,        32'd0,        5'd18, 32'd5,        1, 1'b0);
    run_op("div ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1, 1'b0);
    run_op("rem ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1, 1'b0);

    // Flush 10 cycles into a DIVU, with a competing start in the flush cycle
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd21; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1; start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd22;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush busy after", {31'd0, busy}, 32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid || busy) vcount++;
      @(posedge clk); #1;
    end
    check("flush no activity", 32'(vcount), 32'd0);
    check("flush result kept", result, 32'd0);
    check("flush rd_out kept", {27'd0, rd_out}, {27'd0, 5'd20});

    // Asynchronous reset mid-CALC
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd77; op_b = 32'd5; rd_in = 5'd23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst valid", {31'd0, valid}, 32'd0);
    check("async rst result", result, 32'd0);
    check("async rst rd_out", {27'd0, rd_out}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("post-rst divu", 3'b101, 32'd77, 32'd5, 5'd24, 32'd15, DIV_LAT, 1'b0);
    run_op("post-rst remu", 3'b111, 32'd77, 32'd5, 5'd25, 32'd2,  DIV_LAT, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
